// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-phase traffic controller.
// Contents:
//   - state encoding (GREEN/YELLOW/ALL_RED/WALK) as localparams and an enum built on them
//   - Prog_Sel field codes selecting a column of the duration table
//   - clamp1(): a programmed duration of 0 is stored as 0 but timed as 1
package traffic_pkg;

   localparam logic [1:0] ST_GREEN  = 2'd0;
   localparam logic [1:0] ST_YELLOW = 2'd1;
   localparam logic [1:0] ST_ALLRED = 2'd2;
   localparam logic [1:0] ST_WALK   = 2'd3;

   typedef enum logic [1:0] {
      GREEN   = ST_GREEN,
      YELLOW  = ST_YELLOW,
      ALL_RED = ST_ALLRED,
      WALK    = ST_WALK
   } state_e;

   localparam logic [1:0] SEL_GREEN  = 2'd0;
   localparam logic [1:0] SEL_YELLOW = 2'd1;
   localparam logic [1:0] SEL_ALLRED = 2'd2;
   localparam logic [1:0] SEL_WALK   = 2'd3;

   function automatic int clamp1(input int dur);
      return (dur < 1) ? 1 : dur;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Countdown for the current light interval.
// Ports:
//   clk, Reset_n  clock and synchronous active-low reset (loads RST_VAL)
//   load          load load_val (clamped to >= 1) at this edge
//   load_val      raw duration from the table or the extension constant
//   tick          1 Hz enable; each tick decrements the count
//   expired       tick while count == 1 (combinational, so the owner can
//                 change state and reload at the very same edge)
module phase_timer
   import traffic_pkg::*;
#(
   parameter int TIME_W  = 4,
   parameter int RST_VAL = 1
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              tick,
   output logic              expired
);

   logic [TIME_W-1:0] count_q;

   assign expired = tick && (count_q == TIME_W'(1));

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         count_q <= TIME_W'(clamp1(RST_VAL));
      end else if (load) begin
         count_q <= TIME_W'(clamp1(int'(load_val)));
      end else if (tick && (count_q > TIME_W'(1))) begin
         count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// N-approach round-robin traffic controller: GREEN -> YELLOW -> ALL_RED -> optional WALK.
// Ports:
//   clk, Reset_n        clock, synchronous active-low reset
//   oneHz_Enable        one-cycle timing tick
//   Sensor              vehicle present per phase (one green extension per green)
//   Walk_Request        pedestrian request per phase, latched until served
//   Prog_En/Phase/Sel/Value  write port of the per-phase duration table
//   Green/Yellow/Red/Walk    registered per-phase lamps
//   Cur_Phase, State    phase being served and its interval
module multi_phase_traffic_controller
   import traffic_pkg::*;
#(
   parameter  int NUM_PHASES = 4,
   parameter  int TIME_W     = 4,
   parameter  int DEF_GREEN  = 6,
   parameter  int DEF_YELLOW = 2,
   parameter  int DEF_ALLRED = 1,
   parameter  int DEF_WALK   = 3,
   parameter  int EXT_TIME   = 3,
   localparam int PH_W       = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  Reset_n,
   input  logic                  oneHz_Enable,
   input  logic [NUM_PHASES-1:0] Sensor,
   input  logic [NUM_PHASES-1:0] Walk_Request,
   input  logic                  Prog_En,
   input  logic [PH_W-1:0]       Prog_Phase,
   input  logic [1:0]            Prog_Sel,
   input  logic [TIME_W-1:0]     Prog_Value,
   output logic [NUM_PHASES-1:0] Green,
   output logic [NUM_PHASES-1:0] Yellow,
   output logic [NUM_PHASES-1:0] Red,
   output logic [NUM_PHASES-1:0] Walk,
   output logic [PH_W-1:0]       Cur_Phase,
   output logic [1:0]            State
);

   state_e                  state_q, state_d;
   logic [PH_W-1:0]         phase_q, phase_d, phase_nxt;
   logic                    ext_q, ext_d;
   logic [NUM_PHASES-1:0]   wlatch_q, wlatch_d, wlatch_clr;
   logic [TIME_W-1:0]       dur_q [NUM_PHASES][4];
   logic [TIME_W-1:0]       load_val;
   logic                    expired;
   logic [NUM_PHASES-1:0]   green_q, yellow_q, red_q, walk_q;

   assign phase_nxt = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;

   // Every expiry reloads the countdown, so the load strobe is the expiry itself.
   phase_timer #(
      .TIME_W (TIME_W),
      .RST_VAL(DEF_ALLRED)
   ) u_timer (
      .clk     (clk),
      .Reset_n (Reset_n),
      .load    (expired),
      .load_val(load_val),
      .tick    (oneHz_Enable),
      .expired (expired)
   );

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path infers a latch.
      state_d    = state_q;
      phase_d    = phase_q;
      ext_d      = ext_q;
      wlatch_clr = '0;
      load_val   = dur_q[phase_q][SEL_GREEN];
      if (expired) begin
         unique case (state_q)
            GREEN: begin
               if (Sensor[phase_q] && !ext_q) begin
                  load_val = TIME_W'(EXT_TIME);
                  ext_d    = 1'b1;
               end else begin
                  state_d  = YELLOW;
                  load_val = dur_q[phase_q][SEL_YELLOW];
               end
            end
            YELLOW: begin
               state_d  = ALL_RED;
               load_val = dur_q[phase_q][SEL_ALLRED];
            end
            ALL_RED: begin
               if (wlatch_q[phase_q]) begin
                  state_d  = WALK;
                  load_val = dur_q[phase_q][SEL_WALK];
               end else begin
                  state_d  = GREEN;
                  phase_d  = phase_nxt;
                  ext_d    = 1'b0;
                  load_val = dur_q[phase_nxt][SEL_GREEN];
               end
            end
            WALK: begin
               wlatch_clr[phase_q] = 1'b1;
               state_d  = GREEN;
               phase_d  = phase_nxt;
               ext_d    = 1'b0;
               load_val = dur_q[phase_nxt][SEL_GREEN];
            end
            default: ;
         endcase
      end
      // A request arriving in the WALK exit cycle re-arms the latch for next rotation.
      wlatch_d = (wlatch_q & ~wlatch_clr) | Walk_Request;
   end

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         state_q  <= ALL_RED;
         phase_q  <= PH_W'(NUM_PHASES - 1);
         ext_q    <= 1'b0;
         wlatch_q <= '0;
         // NOTE: the duration table is reset flops rather than RAM because reset must restore the defaults.
         for (int p = 0; p < NUM_PHASES; p++) begin
            dur_q[p][SEL_GREEN]  <= TIME_W'(DEF_GREEN);
            dur_q[p][SEL_YELLOW] <= TIME_W'(DEF_YELLOW);
            dur_q[p][SEL_ALLRED] <= TIME_W'(DEF_ALLRED);
            dur_q[p][SEL_WALK]   <= TIME_W'(DEF_WALK);
         end
         green_q  <= '0;
         yellow_q <= '0;
         red_q    <= '1;
         walk_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         phase_q  <= phase_d;
         ext_q    <= ext_d;
         wlatch_q <= wlatch_d;
         // Loads above read dur_q before this write lands, so a same-cycle load sees the old value.
         if (Prog_En && (int'(Prog_Phase) < NUM_PHASES)) begin
            dur_q[Prog_Phase][Prog_Sel] <= Prog_Value;
         end
         // Lamps are decoded from the next state so they change on the same edge as State.
         for (int i = 0; i < NUM_PHASES; i++) begin
            green_q[i]  <= (state_d == GREEN)  && (phase_d == PH_W'(i));
            yellow_q[i] <= (state_d == YELLOW) && (phase_d == PH_W'(i));
            red_q[i]    <= !(((state_d == GREEN) || (state_d == YELLOW)) && (phase_d == PH_W'(i)));
            walk_q[i]   <= (state_d == WALK)   && (phase_d == PH_W'(i));
         end
      end
   end

   assign Green     = green_q;
   assign Yellow    = yellow_q;
   assign Red       = red_q;
   assign Walk      = walk_q;
   assign Cur_Phase = phase_q;
   assign State     = state_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Bench for multi_phase_traffic_controller: three instances (N=4, N=2/TIME_W=6, N=3)
// checked every cycle against an interval-level model, plus literal duration checks.
module tb_multi_phase_traffic_controller;

   localparam int NI = 3;

   int n_pass  = 0;
   int n_total = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n  [NI];
   logic       tick   [NI];
   logic [3:0] sensor [NI];
   logic [3:0] wreq   [NI];
   logic       pen    [NI];
   logic [1:0] pph    [NI];
   logic [1:0] psel   [NI];
   logic [5:0] pval   [NI];

   wire [3:0] g_o [NI];
   wire [3:0] y_o [NI];
   wire [3:0] r_o [NI];
   wire [3:0] w_o [NI];
   wire [1:0] ph_o [NI];
   wire [1:0] st_o [NI];

   wire [1:0] g_b, y_b, r_b, w_b;
   wire [0:0] ph_b;
   wire [2:0] g_c, y_c, r_c, w_c;

   multi_phase_traffic_controller #(.NUM_PHASES(4), .TIME_W(4)) dut_a (
      .clk(clk), .Reset_n(rst_n[0]), .oneHz_Enable(tick[0]), .Sensor(sensor[0]),
      .Walk_Request(wreq[0]), .Prog_En(pen[0]), .Prog_Phase(pph[0]), .Prog_Sel(psel[0]),
      .Prog_Value(pval[0][3:0]), .Green(g_o[0]), .Yellow(y_o[0]), .Red(r_o[0]),
      .Walk(w_o[0]), .Cur_Phase(ph_o[0]), .State(st_o[0]));

   multi_phase_traffic_controller #(.NUM_PHASES(2), .TIME_W(6)) dut_b (
      .clk(clk), .Reset_n(rst_n[1]), .oneHz_Enable(tick[1]), .Sensor(sensor[1][1:0]),
      .Walk_Request(wreq[1][1:0]), .Prog_En(pen[1]), .Prog_Phase(pph[1][0:0]), .Prog_Sel(psel[1]),
      .Prog_Value(pval[1]), .Green(g_b), .Yellow(y_b), .Red(r_b),
      .Walk(w_b), .Cur_Phase(ph_b), .State(st_o[1]));

   multi_phase_traffic_controller #(.NUM_PHASES(3), .TIME_W(4)) dut_c (
      .clk(clk), .Reset_n(rst_n[2]), .oneHz_Enable(tick[2]), .Sensor(sensor[2][2:0]),
      .Walk_Request(wreq[2][2:0]), .Prog_En(pen[2]), .Prog_Phase(pph[2]), .Prog_Sel(psel[2]),
      .Prog_Value(pval[2][3:0]), .Green(g_c), .Yellow(y_c), .Red(r_c),
      .Walk(w_c), .Cur_Phase(ph_o[2]), .State(st_o[2]));

   assign g_o[1]  = {2'b00, g_b};
   assign y_o[1]  = {2'b00, y_b};
   assign r_o[1]  = {2'b00, r_b};
   assign w_o[1]  = {2'b00, w_b};
   assign ph_o[1] = {1'b0, ph_b};
   assign g_o[2]  = {1'b0, g_c};
   assign y_o[2]  = {1'b0, y_c};
   assign r_o[2]  = {1'b0, r_c};
   assign w_o[2]  = {1'b0, w_c};

   function automatic int np(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 3;
   endfunction
   function automatic int tw(input int k);
      return (k == 1) ? 6 : 4;
   endfunction
   function automatic int def_dur(input int sel);
      return (sel == 0) ? 6 : (sel == 1) ? 2 : (sel == 2) ? 1 : 3;
   endfunction
   function automatic int max1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic check(input bit ok, input string nm, input int act, input int exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Reference model: interval name (0=G 1=Y 2=AR 3=WALK), phase, ticks remaining.
   bit         m_valid [NI];
   int         m_st    [NI];
   int         m_ph    [NI];
   int         m_rem   [NI];
   bit         m_ext   [NI];
   logic [3:0] m_latch [NI];
   int         m_tab   [NI][4][4];

   task automatic model_step(input int k);
      int         n, p, nx, msk;
      logic [3:0] keep;
      n   = np(k);
      msk = (1 << n) - 1;
      if (!rst_n[k]) begin
         m_valid[k] = 1'b1;
         m_st[k] = 2; m_ph[k] = n - 1; m_rem[k] = max1(def_dur(2));
         m_ext[k] = 1'b0; m_latch[k] = 4'b0;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m_tab[k][i][j] = def_dur(j);
         return;
      end
      if (!m_valid[k]) return;
      p    = m_ph[k];
      nx   = (p + 1) % n;
      keep = m_latch[k];
      if (tick[k]) begin
         if (m_rem[k] > 1) m_rem[k] = m_rem[k] - 1;
         else if (m_st[k] == 0 && sensor[k][p] && !m_ext[k]) begin
            m_rem[k] = 3; m_ext[k] = 1'b1;
         end else if (m_st[k] == 0) begin
            m_st[k] = 1; m_rem[k] = max1(m_tab[k][p][1]);
         end else if (m_st[k] == 1) begin
            m_st[k] = 2; m_rem[k] = max1(m_tab[k][p][2]);
         end else if (m_st[k] == 2 && m_latch[k][p]) begin
            m_st[k] = 3; m_rem[k] = max1(m_tab[k][p][3]);
         end else begin
            if (m_st[k] == 3) keep[p] = 1'b0;
            m_st[k] = 0; m_ph[k] = nx; m_ext[k] = 1'b0; m_rem[k] = max1(m_tab[k][nx][0]);
         end
      end
      m_latch[k] = keep | (wreq[k] & 4'(msk));
      if (pen[k] && (int'(pph[k]) & ((k == 1) ? 1 : 3)) < n)
         m_tab[k][int'(pph[k]) & ((k == 1) ? 1 : 3)][psel[k]] = int'(pval[k]) & ((1 << tw(k)) - 1);
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) model_step(k);
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (m_valid[k]) begin
            int eg, ey, ew, er;
            eg = (m_st[k] == 0) ? (1 << m_ph[k]) : 0;
            ey = (m_st[k] == 1) ? (1 << m_ph[k]) : 0;
            ew = (m_st[k] == 3) ? (1 << m_ph[k]) : 0;
            er = ~(eg | ey) & ((1 << np(k)) - 1);
            check(int'(st_o[k]) == m_st[k], $sformatf("i%0d State", k), int'(st_o[k]), m_st[k]);
            check(int'(ph_o[k]) == m_ph[k], $sformatf("i%0d Cur_Phase", k), int'(ph_o[k]), m_ph[k]);
            check(int'(g_o[k]) == eg, $sformatf("i%0d Green", k), int'(g_o[k]), eg);
            check(int'(y_o[k]) == ey, $sformatf("i%0d Yellow", k), int'(y_o[k]), ey);
            check(int'(r_o[k]) == er, $sformatf("i%0d Red", k), int'(r_o[k]), er);
            check(int'(w_o[k]) == ew, $sformatf("i%0d Walk", k), int'(w_o[k]), ew);
         end
      end
   end

   // Waits for (st,ph), then counts ticks spent there; optional table write on entry
   // and optional walk request for the phase in the exit cycle.
   task automatic measure(input int k, input int st, input int ph, input int exp, input string nm,
                          input bit wr = 1'b0, input int wr_ph = 0, input int wr_sel = 0,
                          input int wr_val = 0, input bit pulse_last = 1'b0);
      int n, guard;
      bit first;
      n = 0; guard = 0; first = 1'b1;
      while (!(int'(st_o[k]) == st && int'(ph_o[k]) == ph) && guard < 400) begin
         @(negedge clk); guard++;
      end
      if (guard >= 400) begin
         check(1'b0, {nm, " entry timeout"}, int'(st_o[k]), st);
         return;
      end
      while (int'(st_o[k]) == st && int'(ph_o[k]) == ph && guard < 400) begin
         pen[k] = wr && first;
         if (wr && first) begin
            pph[k] = 2'(wr_ph); psel[k] = 2'(wr_sel); pval[k] = 6'(wr_val);
         end
         first = 1'b0;
         if (pulse_last) wreq[k] = (tick[k] && n == exp - 1) ? 4'(1 << ph) : 4'b0;
         if (tick[k]) n++;
         @(negedge clk); guard++;
      end
      pen[k] = 1'b0;
      if (pulse_last) wreq[k] = 4'b0;
      check(n == exp, nm, n, exp);
   endtask

   task automatic wait_state(input int k, input int st, input int ph, input string nm);
      int guard;
      guard = 0;
      while (!(int'(st_o[k]) == st && int'(ph_o[k]) == ph) && guard < 400) begin
         @(negedge clk); guard++;
      end
      if (guard >= 400) check(1'b0, {nm, " timeout"}, int'(st_o[k]), st);
   endtask

   task automatic check_reset_state(input int k, input string nm);
      check(int'(st_o[k]) == 2, {nm, " State"}, int'(st_o[k]), 2);
      check(int'(ph_o[k]) == np(k) - 1, {nm, " Cur_Phase"}, int'(ph_o[k]), np(k) - 1);
      check(int'(r_o[k]) == (1 << np(k)) - 1, {nm, " Red"}, int'(r_o[k]), (1 << np(k)) - 1);
      check(int'(g_o[k] | y_o[k] | w_o[k]) == 0, {nm, " G|Y|W"}, int'(g_o[k] | y_o[k] | w_o[k]), 0);
   endtask

   task automatic randomize_inputs(input int k, input bit allow_rst);
      sensor[k] = 4'($urandom_range(0, 15));
      wreq[k]   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      pen[k]    = ($urandom_range(0, 9) == 0);
      pph[k]    = 2'($urandom_range(0, 3));
      psel[k]   = 2'($urandom_range(0, 3));
      pval[k]   = 6'($urandom_range(0, 15));
      rst_n[k]  = !(allow_rst && $urandom_range(0, 299) == 0);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k] = 1'b0; tick[k] = 1'b0; sensor[k] = 4'b0; wreq[k] = 4'b0;
         pen[k] = 1'b0; pph[k] = 2'b0; psel[k] = 2'b0; pval[k] = 6'b0;
      end
      fork
         begin : tick_gen
            int c;
            c = 0;
            forever begin
               @(posedge clk); #1;
               c++;
               tick[0] = 1'($urandom_range(0, 1));
               tick[1] = (c % 3 == 0);
               tick[2] = 1'($urandom_range(0, 1));
            end
         end
      join_none
      fork
         begin : flow_a
            repeat (2) @(negedge clk);
            check_reset_state(0, "A reset");
            rst_n[0] = 1'b1;
            measure(0, 2, 3, 1, "A first allred");
            for (int p = 0; p < 4; p++) begin
               measure(0, 0, p, 6, $sformatf("A green%0d", p));
               measure(0, 1, p, 2, $sformatf("A yellow%0d", p));
               measure(0, 2, p, 1, $sformatf("A allred%0d", p));
            end
            measure(0, 0, 0, 6, "A green0 wrap");
            sensor[0] = 4'b0010;
            measure(0, 0, 1, 9, "A extended green1");
            measure(0, 1, 1, 2, "A yellow1 after ext");
            sensor[0] = 4'b0000;
            wait_state(0, 0, 0, "A wait green0");
            wreq[0] = 4'b0100;
            @(negedge clk);
            wreq[0] = 4'b0000;
            measure(0, 2, 2, 1, "A allred2 before walk");
            measure(0, 3, 2, 3, "A walk2", 1'b0, 0, 0, 0, 1'b1);
            check(int'(st_o[0]) == 0 && int'(ph_o[0]) == 3, "A green3 after walk",
                  int'(st_o[0]) * 4 + int'(ph_o[0]), 3);
            measure(0, 3, 2, 3, "A walk2 re-served");
            measure(0, 2, 2, 1, "A allred2 no walk");
            check(int'(st_o[0]) == 0 && int'(ph_o[0]) == 3, "A latch cleared",
                  int'(st_o[0]) * 4 + int'(ph_o[0]), 3);
            measure(0, 0, 1, 6, "A green1 during write", 1'b1, 1, 0, 10);
            measure(0, 0, 1, 10, "A green1 reprogrammed", 1'b1, 1, 0, 0);
            measure(0, 0, 1, 1, "A green1 zero");
            wait_state(0, 1, 2, "A wait yellow2");
            rst_n[0] = 1'b0;
            @(negedge clk);
            check_reset_state(0, "A mid reset");
            rst_n[0] = 1'b1;
            measure(0, 2, 3, 1, "A allred after reset");
            measure(0, 0, 1, 6, "A green1 default again");
            repeat (1500) begin
               randomize_inputs(0, 1'b1);
               @(negedge clk);
            end
         end
         begin : flow_b
            repeat (2) @(negedge clk);
            check_reset_state(1, "B reset");
            rst_n[1] = 1'b1;
            pen[1] = 1'b1; pph[1] = 2'd1; psel[1] = 2'd0; pval[1] = 6'd40;
            @(negedge clk);
            pen[1] = 1'b0;
            measure(1, 0, 0, 6, "B green0");
            measure(1, 0, 1, 40, "B green1 40");
            measure(1, 1, 1, 2, "B yellow1");
            measure(1, 2, 1, 1, "B allred1");
            check(int'(st_o[1]) == 0 && int'(ph_o[1]) == 0, "B wrap to green0",
                  int'(st_o[1]) * 4 + int'(ph_o[1]), 0);
         end
         begin : flow_c
            repeat (2) @(negedge clk);
            check_reset_state(2, "C reset");
            rst_n[2] = 1'b1;
            repeat (2000) begin
               randomize_inputs(2, 1'b1);
               @(negedge clk);
            end
         end
      join
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
